qpsk_demod: RTL

- Receive-side counterpart of qpsk_mod: accepts signed 12-bit baseband I/Q samples and integrates each rail over one symbol period (integrate-and-dump).
- Slices the sign of each integral to recover one I bit and one Q bit per symbol.
- Presents each recovered symbol on a valid/ready output register.
- Sits between the ADC/loopback sample path and the bit deserializer, all in the system clock domain.

---
 rtl/qpsk_demod.sv | 130 +++++++++++++
 1 files changed

// File: rtl/qpsk_demod.sv
// QPSK integrate-and-dump demodulator: sums SPS samples per rail, slices the
// sign of each sum into one I bit and one Q bit, and holds the recovered
// symbol in a valid/ready output register.
module qpsk_demod #(
  parameter int DATA_W = 12,
  parameter int SPS    = 8,
  parameter int OFFSET = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] i_I,
  input  logic signed [DATA_W-1:0] i_Q,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_sync,
  output logic                     o_I,
  output logic                     o_Q,
  output logic                     o_valid,
  input  logic                     i_ready
);

  localparam int CNT_W = $clog2(SPS);
  localparam int ACC_W = DATA_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPS - 1);
  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((OFFSET > 0) ? OFFSET - 1 : 0);

  typedef enum logic {SKIP, INTEG} state_t;
  localparam state_t START = (OFFSET == 0) ? INTEG : SKIP;

  // Sign-extend a sample to accumulator width; the accumulator is sized so
  // that a full window of extreme samples can never wrap.
  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] x);
    return {{(ACC_W - DATA_W){x[DATA_W-1]}}, x};
  endfunction

  // Hard decision: non-negative sums (including exact zero) map to 1.
  function automatic logic slice(input logic signed [ACC_W-1:0] s);
    return ~s[ACC_W-1];
  endfunction

  state_t                    state_p0, state_n;
  logic [CNT_W-1:0]          cnt_p0, cnt_n;
  logic signed [ACC_W-1:0]   acc_i_p0, acc_q_p0, acc_i_n, acc_q_n;
  logic signed [ACC_W-1:0]   sum_i, sum_q;
  logic                      load;
  logic                      accept;
  logic                      vld_p1, sym_i_p1, sym_q_p1;

  // Stall only when the window is about to close and the held symbol cannot leave.
  assign o_ready = rst_n && !(state_p0 == INTEG && cnt_p0 == CNT_LAST && vld_p1 && !i_ready);
  assign accept  = i_valid && o_ready;

  // Framing FSM and accumulator next-state; sync overrides any accepted sample.
  always_comb begin
    state_n = state_p0;
    cnt_n   = cnt_p0;
    acc_i_n = acc_i_p0;
    acc_q_n = acc_q_p0;
    load    = 1'b0;
    sum_i   = acc_i_p0 + sext(i_I);
    sum_q   = acc_q_p0 + sext(i_Q);
    if (i_sync) begin
      acc_i_n = '0;
      acc_q_n = '0;
      cnt_n   = '0;
      state_n = START;
    end else if (accept) begin
      case (state_p0)
        SKIP: begin
          if (cnt_p0 == SKIP_LAST) begin
            cnt_n   = '0;
            state_n = INTEG;
          end else begin
            cnt_n = cnt_p0 + CNT_W'(1);
          end
        end
        INTEG: begin
          if (cnt_p0 == CNT_LAST) begin
            acc_i_n = '0;
            acc_q_n = '0;
            cnt_n   = '0;
            load    = 1'b1;
          end else begin
            acc_i_n = sum_i;
            acc_q_n = sum_q;
            cnt_n   = cnt_p0 + CNT_W'(1);
          end
        end
        default: state_n = START;
      endcase
    end
  end

  // ---- stage p0: integration state ----
  // Integration state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= START;
      cnt_p0   <= '0;
      acc_i_p0 <= '0;
      acc_q_p0 <= '0;
    end else begin
      state_p0 <= state_n;
      cnt_p0   <= cnt_n;
      acc_i_p0 <= acc_i_n;
      acc_q_p0 <= acc_q_n;
    end
  end

  // ---- stage p1: symbol output register ----
  // Load a new symbol at window close; otherwise drop valid once transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      sym_i_p1 <= 1'b0;
      sym_q_p1 <= 1'b0;
    end else if (load) begin
      vld_p1   <= 1'b1;
      sym_i_p1 <= slice(sum_i);
      sym_q_p1 <= slice(sum_q);
    end else if (vld_p1 && i_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign o_valid = vld_p1;
  assign o_I     = sym_i_p1;
  assign o_Q     = sym_q_p1;

endmodule
